// File: rtl/register_file.sv
// Register file: 2**ADDRESS_WIDTH x DATA_WIDTH, one synchronous write port, two combinational reads.
// Define REGISTER_FILE_BYPASS_EN to forward same-cycle write data to the read ports.

module register_file #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     register_write_enable,
    input  logic [ADDRESS_WIDTH-1:0] register_write_address,
    input  logic [DATA_WIDTH-1:0]    register_write_data,
    input  logic                     register_read_enable_1,
    input  logic [ADDRESS_WIDTH-1:0] register_read_address_1,
    output logic [DATA_WIDTH-1:0]    register_read_data_1,
    input  logic                     register_read_enable_2,
    input  logic [ADDRESS_WIDTH-1:0] register_read_address_2,
    output logic [DATA_WIDTH-1:0]    register_read_data_2
);

    localparam int unsigned Depth = 1 << ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [Depth];
    logic [DATA_WIDTH-1:0] regs_d [Depth];

    logic write_valid;
    logic bypass_1;
    logic bypass_2;

    // Reset wins over a coincident write; r0 is never written.
    assign write_valid = register_write_enable && (register_write_address != '0) && !reset;

`ifdef REGISTER_FILE_BYPASS_EN
    assign bypass_1 = write_valid && (register_read_address_1 == register_write_address);
    assign bypass_2 = write_valid && (register_read_address_2 == register_write_address);
`else
    assign bypass_1 = 1'b0;
    assign bypass_2 = 1'b0;
`endif

    always_comb begin
        regs_d = regs_q;
        if (reset) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                regs_d[i] = '0;
            end
        end else if (write_valid) begin
            regs_d[register_write_address] = register_write_data;
        end
    end

    always_ff @(posedge clock) begin
        regs_q <= regs_d;
    end

    // Zero rules (reset, disabled port, r0) take priority over bypass.
    always_comb begin
        register_read_data_1 = '0;
        if (!reset && register_read_enable_1 && (register_read_address_1 != '0)) begin
            if (bypass_1) begin
                register_read_data_1 = register_write_data;
            end else begin
                register_read_data_1 = regs_q[register_read_address_1];
            end
        end
    end

    always_comb begin
        register_read_data_2 = '0;
        if (!reset && register_read_enable_2 && (register_read_address_2 != '0)) begin
            if (bypass_2) begin
                register_read_data_2 = register_write_data;
            end else begin
                register_read_data_2 = regs_q[register_read_address_2];
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: vector table plus hand sequences, scoreboard queue.
// Expectations follow the build: REGISTER_FILE_BYPASS_EN selects the bypass column.

module tb_register_file;

`ifdef REGISTER_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        register_write_enable;
    logic [4:0]  register_write_address;
    logic [31:0] register_write_data;
    logic        register_read_enable_1;
    logic [4:0]  register_read_address_1;
    logic [31:0] register_read_data_1;
    logic        register_read_enable_2;
    logic [4:0]  register_read_address_2;
    logic [31:0] register_read_data_2;

    register_file #(
        .DATA_WIDTH   (32),
        .ADDRESS_WIDTH(5)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .register_write_enable  (register_write_enable),
        .register_write_address (register_write_address),
        .register_write_data    (register_write_data),
        .register_read_enable_1 (register_read_enable_1),
        .register_read_address_1(register_read_address_1),
        .register_read_data_1   (register_read_data_1),
        .register_read_enable_2 (register_read_enable_2),
        .register_read_address_2(register_read_address_2),
        .register_read_data_2   (register_read_data_2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic [31:0] e1;   // expected without bypass
        logic [31:0] e2;
        logic [31:0] e1b;  // expected with bypass
        logic [31:0] e2b;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t        sb_q[$];
    vec_t        vecs[14];
    logic [31:0] model[32];
    int          n_cmp;
    int          n_err;

    task automatic check_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_underflow: no expected entry queued");
            return;
        end
        e = sb_q.pop_front();
        n_cmp++;
        if (register_read_data_1 !== e.e1) begin
            n_err++;
            $display("FAIL %s port1: got %h want %h", e.name, register_read_data_1, e.e1);
        end
        n_cmp++;
        if (register_read_data_2 !== e.e2) begin
            n_err++;
            $display("FAIL %s port2: got %h want %h", e.name, register_read_data_2, e.e2);
        end
    endtask

    // One clock cycle: drive just after posedge, check at negedge, let the edge commit.
    task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic re1, input logic [4:0] ra1,
                         input logic re2, input logic [4:0] ra2, input logic [31:0] e1,
                         input logic [31:0] e2, input string name);
        exp_t e;
        reset                   = rst;
        register_write_enable   = we;
        register_write_address  = wa;
        register_write_data     = wd;
        register_read_enable_1  = re1;
        register_read_address_1 = ra1;
        register_read_enable_2  = re2;
        register_read_address_2 = ra2;
        e.name = name;
        e.e1   = e1;
        e.e2   = e2;
        sb_q.push_back(e);
        @(negedge clock);
        check_out();
        @(posedge clock);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (we && wa != 5'd0) begin
            model[wa] = wd;
        end
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 32; i++) model[i] = '0;

        //           name      rst we wa     wd            re1 ra1    re2 ra2    e1            e2            e1b           e2b
        vecs[0]  = '{"rst",    1, 1, 5'd5, 32'h0000_0055, 1, 5'd5, 1, 5'd0, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[1]  = '{"wr5",    0, 1, 5'd5, 32'hDEAD_BEEF, 1, 5'd5, 1, 5'd5, 32'h0,        32'h0,        32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[2]  = '{"rd5",    0, 0, 5'd0, 32'h0,         1, 5'd5, 1, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[3]  = '{"wr0",    0, 1, 5'd0, 32'h1234_5678, 1, 5'd0, 1, 5'd5, 32'h0,        32'hDEAD_BEEF, 32'h0,        32'hDEAD_BEEF};
        vecs[4]  = '{"rd0",    0, 0, 5'd0, 32'h0,         1, 5'd0, 1, 5'd0, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[5]  = '{"pre7",   0, 1, 5'd7, 32'h0000_0001, 1, 5'd5, 1, 5'd0, 32'hDEAD_BEEF, 32'h0,        32'hDEAD_BEEF, 32'h0};
        vecs[6]  = '{"wr7",    0, 1, 5'd7, 32'h0000_0002, 1, 5'd7, 0, 5'd7, 32'h1,        32'h0,        32'h2,        32'h0};
        vecs[7]  = '{"rd7",    0, 0, 5'd0, 32'h0,         1, 5'd7, 1, 5'd7, 32'h2,        32'h2,        32'h2,        32'h2};
        vecs[8]  = '{"wr9rst", 1, 1, 5'd9, 32'hA5A5_A5A5, 1, 5'd9, 1, 5'd5, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[9]  = '{"rd9",    0, 0, 5'd0, 32'h0,         1, 5'd9, 1, 5'd5, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[10] = '{"wr3",    0, 1, 5'd3, 32'hCAFE_F00D, 1, 5'd3, 0, 5'd3, 32'h0,        32'h0,        32'hCAFE_F00D, 32'h0};
        vecs[11] = '{"en0",    0, 0, 5'd0, 32'h0,         0, 5'd3, 1, 5'd3, 32'h0,        32'hCAFE_F00D, 32'h0,        32'hCAFE_F00D};
        vecs[12] = '{"byp2",   0, 1, 5'd3, 32'h1111_2222, 1, 5'd4, 1, 5'd3, 32'h0,        32'hCAFE_F00D, 32'h0,        32'h1111_2222};
        vecs[13] = '{"we0",    0, 0, 5'd4, 32'hFFFF_FFFF, 1, 5'd4, 1, 5'd3, 32'h0,        32'h1111_2222, 32'h0,        32'h1111_2222};

        reset                   = 1'b1;
        register_write_enable   = 1'b0;
        register_write_address  = '0;
        register_write_data     = '0;
        register_read_enable_1  = 1'b0;
        register_read_address_1 = '0;
        register_read_enable_2  = 1'b0;
        register_read_address_2 = '0;
        @(posedge clock);
        #1;

        // Every address reads zero after reset.
        drive(1, 0, 5'd0, 32'h0, 1, 5'd0, 1, 5'd0, 32'h0, 32'h0, "init_rst");
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 5'd0, 32'h0, 1, 5'(i), 1, 5'(31 - i), 32'h0, 32'h0, "rst_sweep");
        end

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re1, vecs[i].ra1,
                  vecs[i].re2, vecs[i].ra2, BYPASS ? vecs[i].e1b : vecs[i].e1,
                  BYPASS ? vecs[i].e2b : vecs[i].e2, vecs[i].name);
        end

        // Fill every register with random data, then read back in crossed order.
        drive(1, 0, 5'd0, 32'h0, 1, 5'd3, 1, 5'd7, 32'h0, 32'h0, "fill_rst");
        for (int i = 1; i < 32; i++) begin
            logic [31:0] wd;
            wd = $urandom;
            drive(0, 1, 5'(i), wd, 1, 5'(i), 1, 5'(i - 1), BYPASS ? wd : model[i],
                  model[i - 1], "fill_wr");
        end
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 5'd0, 32'h0, 1, 5'(i), 1, 5'(31 - i), model[i], model[31 - i],
                  "fill_rd");
        end

        // Reset between writes clears everything.
        drive(1, 0, 5'd0, 32'h0, 1, 5'd1, 1, 5'd31, 32'h0, 32'h0, "mid_rst");
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 5'd0, 32'h0, 1, 5'(i), 1, 5'(i), 32'h0, 32'h0, "post_rst");
        end

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the width of each general-purpose register.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 5, the register index width; the depth is 2**ADDRESS_WIDTH entries.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, the reset; it is synchronous and active-high.
REQ-005 The block SHALL have port register_write_enable, input, 1, the write-back strobe from the MEM/WB latch.
REQ-006 The block SHALL have port register_write_address, input, ADDRESS_WIDTH, the destination register index.
REQ-007 The block SHALL have port register_write_data, input, DATA_WIDTH, the write-back value.
REQ-008 The block SHALL have port register_read_enable_1, input, 1, the read strobe for port 1 (rs).
REQ-009 The block SHALL have port register_read_address_1, input, ADDRESS_WIDTH, the port 1 index.
REQ-010 The block SHALL have port register_read_data_1, output, DATA_WIDTH, the port 1 read value.
REQ-011 The block SHALL have port register_read_enable_2, input, 1, the read strobe for port 2 (rt).
REQ-012 The block SHALL have port register_read_address_2, input, ADDRESS_WIDTH, the port 2 index.
REQ-013 The block SHALL have port register_read_data_2, output, DATA_WIDTH, the port 2 read value.

Function
REQ-014 The storage SHALL be 2**ADDRESS_WIDTH registers of DATA_WIDTH bits each.
REQ-015 Writes SHALL be synchronous: at a rising clock edge with reset=0, register_write_enable=1 and register_write_address!=0, the addressed register takes register_write_data.
REQ-016 Writes to address 0 SHALL be discarded; register 0 SHALL always read as 0.
REQ-017 Reads SHALL be combinational; data is valid in the same cycle as the address, with zero cycles of latency.
REQ-018 A read port with its read enable at 0 SHALL output 0.
REQ-019 A read port addressing register 0 SHALL output 0 regardless of any write to register 0.
REQ-020 While reset=1, both read data outputs SHALL be 0.
REQ-021 Both read ports SHALL be independent; both ports reading the same address SHALL return identical values.
REQ-022 A completed write SHALL be visible on both read ports from the cycle after the write edge onward.
REQ-023 Same-cycle read-during-write behaviour SHALL be governed solely by the Configuration section.

Reset
REQ-024 At a rising edge with reset=1, all registers SHALL be cleared to 0.
REQ-025 A write presented in the same cycle as reset=1 SHALL be discarded; reset wins.
REQ-026 Reset asserted between writes SHALL clear all earlier written values; reads in the cycle after reset deasserts return 0 for every address.

Configuration
REQ-027 The macro REGISTER_FILE_BYPASS_EN SHALL control write-to-read bypass.
REQ-028 With REGISTER_FILE_BYPASS_EN defined, when the following hold in the same cycle, the read port SHALL output register_write_data, not the stored value:
- read enable=1
- read address equals register_write_address
- register_write_enable=1
- the address is not 0
- reset=0
REQ-029 Without REGISTER_FILE_BYPASS_EN, a same-cycle read SHALL return the old stored value; the new value appears only in the next cycle.
REQ-030 With the macro defined, bypass SHALL apply to each port independently and SHALL never override the zero rules of REQ-018 to REQ-020.

Verification
REQ-031 Reset, then read all 32 addresses on both ports -> every read returns 0x00000000.
REQ-032 Write 0xDEADBEEF to r5; next cycle read r5 on port 1 and r5 on port 2 -> both return 0xDEADBEEF.
REQ-033 Write 0x12345678 to r0; next cycle read r0 -> returns 0x00000000, including the same cycle under bypass.
REQ-034 Preload r7=0x1, then write r7=0x2 while reading r7 on port 1 in the same cycle:
- with bypass -> 0x2
- without bypass -> 0x1
- next cycle, either build -> 0x2
REQ-035 Write r9=0xA5A5A5A5 and assert reset together, then read r9 after release -> 0x00000000; read with enable=0 on a nonzero register -> 0x00000000.
